// File: rtl/pipe_stage_elastic_if.sv
// Valid/ready beat channel carrying one payload word plus control bundle.
// master drives the beat, slave returns ready.
interface pipe_stage_elastic_if #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 24
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;

  modport master (
    output valid,
    output data,
    output ctrl,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  ctrl,
    output ready
  );
endinterface

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register: main entry + skid entry, flush squashes both.
// Define PIPE_STAGE_STALL_CNT_EN to add the saturating stall_cnt debug port.
module pipe_stage_elastic #(
  parameter int                 DATA_W   = 64,
  parameter int                 CTRL_W   = 24,
  parameter logic [CTRL_W-1:0]  CTRL_NOP = '0
) (
  input  logic                  Clk,
  input  logic                  Rst,
  pipe_stage_elastic_if.slave   up,
  pipe_stage_elastic_if.master  down,
  input  logic                  flush,
  output logic [1:0]            occupancy
`ifdef PIPE_STAGE_STALL_CNT_EN
  ,
  output logic [31:0]           stall_cnt
`endif
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;
  } beat_t;

  localparam beat_t BEAT_RST = '{
    data: '0,
    ctrl: CTRL_NOP
  };

  logic  mainValid;
  logic  skidValid;
  beat_t mainBeat;
  beat_t skidBeat;
  beat_t inBeat;

  logic  xferIn;
  logic  mainFree;

  assign inBeat.data = up.data;
  assign inBeat.ctrl = up.ctrl;

  // Ready comes only from the skid flag, so out_ready never reaches in_ready.
  assign up.ready = ~skidValid;
  assign xferIn   = up.valid & ~skidValid;
  assign mainFree = ~mainValid | down.ready;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      mainValid <= 1'b0;
      skidValid <= 1'b0;
      mainBeat  <= BEAT_RST;
      skidBeat  <= BEAT_RST;
    end else if (flush) begin
      mainValid <= 1'b0;
      skidValid <= 1'b0;
    end else if (mainFree) begin
      if (skidValid) begin
        mainBeat  <= skidBeat;
        mainValid <= 1'b1;
        skidValid <= 1'b0;
      end else if (xferIn) begin
        mainBeat  <= inBeat;
        mainValid <= 1'b1;
      end else begin
        mainValid <= 1'b0;
      end
    end else if (xferIn) begin
      skidBeat  <= inBeat;
      skidValid <= 1'b1;
    end
  end

  assign down.valid = mainValid;
  assign down.data  = mainBeat.data;
  assign down.ctrl  = mainValid ? mainBeat.ctrl : CTRL_NOP;

  assign occupancy = {1'b0, mainValid} + {1'b0, skidValid};

`ifdef PIPE_STAGE_STALL_CNT_EN
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      stall_cnt <= '0;
    end else if (mainValid && !down.ready && stall_cnt != 32'hFFFF_FFFF) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
